// File: rtl/input_conditioner.sv
// input_conditioner
//   Synchronizes, debounces and edge-detects raw board buttons and switches.
//   Every channel is handled the same way: a SYNC_STAGES-deep synchronizer,
//   a debounce counter, a level register and a registered edge pulse.
//
// Ports
//   CLK100MHZ    in   sole clock, rising edge
//   RST_N        in   asynchronous active-low reset
//   BTN[N_BTN]   in   raw buttons
//   SW[N_SW]     in   raw switches
//   BTN_LEVEL    out  debounced button level
//   BTN_PRESS    out  one-cycle pulse on debounced 0->1
//   BTN_RELEASE  out  one-cycle pulse on debounced 1->0
//   SW_LEVEL     out  debounced switch level
//   SW_CHANGE    out  one-cycle pulse on any debounced switch transition
module input_conditioner #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned N_SW            = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic              CLK100MHZ,
  input  logic              RST_N,
  input  logic [N_BTN-1:0]  BTN,
  input  logic [N_SW-1:0]   SW,
  output logic [N_BTN-1:0]  BTN_LEVEL,
  output logic [N_BTN-1:0]  BTN_PRESS,
  output logic [N_BTN-1:0]  BTN_RELEASE,
  output logic [N_SW-1:0]   SW_LEVEL,
  output logic [N_SW-1:0]   SW_CHANGE
);

  localparam int unsigned N  = N_BTN + N_SW;
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Per-channel state is implied by comparing the synchronized input with
  // the accepted level; no separate state flop is kept.
  typedef enum logic {
    S_IDLE,
    S_COUNT
  } state_e;

  logic [N-1:0]     raw;
  logic [N-1:0]     sync_q [SYNC_STAGES];
  logic [N-1:0]     sync_v;
  logic [CW-1:0]    cnt_q  [N];
  logic [CW-1:0]    cnt_d  [N];
  state_e           state  [N];
  logic [N-1:0]     level_q, level_d;
  logic [N-1:0]     accept;
  logic [N_BTN-1:0] rise_q, rise_d;
  logic [N_BTN-1:0] fall_q, fall_d;
  logic [N_SW-1:0]  chg_q, chg_d;

  assign raw    = {SW, BTN};
  assign sync_v = sync_q[SYNC_STAGES-1];

  always_comb begin
    level_d = level_q;
    accept  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      state[i] = (sync_v[i] != level_q[i]) ? S_COUNT : S_IDLE;
      case (state[i])
        S_IDLE: cnt_d[i] = '0;
        S_COUNT: begin
          if (cnt_q[i] == CNT_LAST) begin
            accept[i]  = 1'b1;
            level_d[i] = ~level_q[i];
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: cnt_d[i] = '0;
      endcase
    end
    // Direction taken from the level before it flips.
    rise_d = accept[N_BTN-1:0] & ~level_q[N_BTN-1:0];
    fall_d = accept[N_BTN-1:0] &  level_q[N_BTN-1:0];
    chg_d  = accept[N-1:N_BTN];
  end

  always_ff @(posedge CLK100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      chg_q   <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      chg_q   <= chg_d;
    end
  end

  assign BTN_LEVEL   = level_q[N_BTN-1:0];
  assign BTN_PRESS   = rise_q;
  assign BTN_RELEASE = fall_q;
  assign SW_LEVEL    = level_q[N-1:N_BTN];
  assign SW_CHANGE   = chg_q;

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL take parameter N_BTN, default 4, meaning the number of push-button channels.
REQ-002 The block SHALL take parameter N_SW, default 4, meaning the number of slide-switch channels.
REQ-003 The block SHALL take parameter SYNC_STAGES, default 2 (legal minimum 2), meaning the synchronizer depth per channel.
REQ-004 The block SHALL take parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz, legal minimum 2), meaning the number of consecutive stable cycles required to accept a change.
REQ-005 CLK100MHZ  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 RST_N  input  1  asynchronous, active-low reset.
REQ-007 BTN  input  N_BTN  raw asynchronous board buttons.
REQ-008 SW  input  N_SW  raw asynchronous board switches.
REQ-009 BTN_LEVEL  output  N_BTN  debounced button level.
REQ-010 BTN_PRESS  output  N_BTN  one-cycle pulse on debounced 0->1.
REQ-011 BTN_RELEASE  output  N_BTN  one-cycle pulse on debounced 1->0.
REQ-012 SW_LEVEL  output  N_SW  debounced switch level.
REQ-013 SW_CHANGE  output  N_SW  one-cycle pulse on any debounced switch transition.

Function
REQ-014 Each of the N_BTN+N_SW channels SHALL be processed independently and identically: synchronizer, debounce counter, level register, edge pulse.
REQ-015 Each raw input SHALL pass through a SYNC_STAGES-deep flop chain before any other logic. No combinational path from raw input to any output is permitted.
REQ-016 Each channel SHALL hold a counter of width clog2(DEBOUNCE_CYCLES) and a level register.
REQ-017 Each channel SHALL implement two states:
  - IDLE: the synchronized value equals the level; the counter is held at 0.
  - COUNT: the synchronized value differs from the level.
REQ-018 IDLE->COUNT: on a cycle where the synchronized value differs from the level, the counter SHALL increment from 0 to 1 at the next edge.
REQ-019 COUNT->IDLE (abort): if the synchronized value equals the level in any cycle, the counter SHALL clear to 0 at the next edge. No level change and no pulse occur.
REQ-020 COUNT->IDLE (accept): when the counter equals DEBOUNCE_CYCLES-1 and a mismatch is still present, the next edge SHALL:
  - invert the level;
  - clear the counter;
  - assert the channel's edge pulse for exactly that one cycle.
REQ-021 Latency: with the raw input stable, the level SHALL change on the (SYNC_STAGES+DEBOUNCE_CYCLES)th rising edge, counting the first edge that samples the new raw value as edge 1.
REQ-022 A raw glitch, or bounce, that keeps the synchronized value mismatched for fewer than DEBOUNCE_CYCLES consecutive cycles SHALL produce no level change and no pulse.
REQ-023 Pulse outputs SHALL be registered. PRESS and RELEASE for the same channel SHALL never be asserted together.
REQ-024 Pulses SHALL be separated by at least DEBOUNCE_CYCLES cycles per channel. No pulse may be asserted in a cycle where the level does not change.
REQ-025 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-026 While RST_N=0, all of the following SHALL be 0 asynchronously: synchronizer flops, counters, level registers, and every output.
REQ-027 Release of RST_N SHALL take effect at the first subsequent rising edge. Only the RST_N input stage is synchronized by the instantiating top.
REQ-028 A raw input that is high at reset release SHALL be treated as a normal 0->1 change. Its level rises and its PRESS/CHANGE pulse fires after the REQ-021 latency.
REQ-029 Reset asserted mid-count SHALL discard the count; no pulse SHALL be emitted for that partial count.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-030 BTN[0] 0->1 before edge 1, then held -> BTN_LEVEL[0]=1 from edge 6; BTN_PRESS[0]=1 for the single cycle after edge 6; all other outputs 0.
REQ-031 BTN[1] bounces 1,0,1,0,1 at one cycle each, then holds 1 -> no pulse during the bounce; BTN_LEVEL[1] rises exactly 6 edges after the final 0->1; exactly one PRESS pulse.
REQ-032 BTN[2] high for 3 cycles then low -> BTN_LEVEL[2] stays 0; BTN_PRESS[2] and BTN_RELEASE[2] never assert.
REQ-033 SW[3] held 1 through reset, then RST_N released -> SW_LEVEL[3]=1 after 6 edges; one SW_CHANGE[3] pulse. Then SW[3] set to 0 -> one SW_CHANGE[3] pulse; SW_LEVEL[3]=0.
REQ-034 BTN[0] released after 2 counted cycles, with RST_N pulsed low mid-count -> all outputs 0 immediately; no RELEASE pulse; BTN_LEVEL[0] stays 0.
REQ-035 BTN[0] and SW[0] change on the same edge -> BTN_PRESS[0] and SW_CHANGE[0] pulse on the same cycle; each channel behaves independently.
